// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared formats, error codes, opcodes, immediate ranges and the RV32I encode function
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } err_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int signed IMM_I_MIN = -2048;
    localparam int signed IMM_I_MAX = 2047;
    localparam int signed IMM_B_MIN = -4096;
    localparam int signed IMM_B_MAX = 4094;
    localparam int signed IMM_J_MIN = -1048576;
    localparam int signed IMM_J_MAX = 1048574;

    typedef struct packed {
        err_e        err;
        logic [31:0] instr;
    } enc_t;

    localparam int ENC_W = $bits(enc_t);

    // Range failures outrank misalignment; the word still carries the truncated immediate bits.
    function automatic enc_t encode_instr(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        enc_t r;
        int signed s;
        s = signed'(imm);
        r.instr = '0;
        r.err = ERR_OK;
        case (fmt)
            FMT_R: r.instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                r.instr = {imm[11:0], rs1, funct3, rd, opcode};
                r.err = (s < IMM_I_MIN || s > IMM_I_MAX) ? ERR_RANGE : ERR_OK;
            end
            FMT_S: begin
                r.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                r.err = (s < IMM_I_MIN || s > IMM_I_MAX) ? ERR_RANGE : ERR_OK;
            end
            FMT_B: begin
                r.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                r.err = (s < IMM_B_MIN || s > IMM_B_MAX) ? ERR_RANGE :
                        imm[0] ? ERR_MISALIGN : ERR_OK;
            end
            FMT_U: begin
                r.instr = {imm[31:12], rd, opcode};
                r.err = (imm[11:0] != 12'd0) ? ERR_ILLEGAL : ERR_OK;
            end
            FMT_J: begin
                r.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                r.err = (s < IMM_J_MIN || s > IMM_J_MAX) ? ERR_RANGE :
                        imm[0] ? ERR_MISALIGN : ERR_OK;
            end
            default: r.err = ERR_ILLEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: power-of-two result buffer with synchronous flush and asynchronous reset
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == DEPTH_C;
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rptr_q];

    // Pointers wrap naturally at the power-of-two depth; flush wins over any push.
    always_comb begin
        do_push = push && !full && !flush;
        do_pop  = pop && !empty;
        wptr_d  = flush ? '0 : wptr_q + AW'(do_push);
        rptr_d  = flush ? '0 : rptr_q + AW'(do_pop);
        cnt_d   = flush ? '0 : cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    // Occupancy and pointer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; unread slots are hidden by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction encoder with range/alignment checks, output FIFO and handshake counters
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);
    enc_t        enc, head;
    logic        full, empty, hs;
    logic [15:0] enc_count_q, enc_count_d, err_count_q, err_count_d;

    assign enc = encode_instr(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

    enc_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(ENC_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .push (in_valid),
        .pop  (out_ready),
        .wdata(enc),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_instr = empty ? '0 : head.instr;
    assign out_err   = empty ? '0 : head.err;
    assign hs        = out_valid && out_ready;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // Saturating counters advance only on output handshakes; flush leaves them alone.
    always_comb begin
        enc_count_d = (hs && enc_count_q != 16'hFFFF) ? enc_count_q + 16'd1 : enc_count_q;
        err_count_d = (hs && out_err != 2'd0 && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  in_fmt, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [1:0]  out_err;
    logic [15:0] enc_count, err_count;
    int          checks = 0;
    int          errors = 0;

    instr_encoder #(.FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_fmt   (in_fmt),
        .in_opcode(in_opcode),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_funct3(in_funct3),
        .in_funct7(in_funct7),
        .in_imm   (in_imm),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_err  (out_err),
        .enc_count(enc_count),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_valid = 1'b1;
        in_fmt = f;
        in_opcode = op;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm = imm;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        step();
        in_valid = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic [1:0] exp_err, input logic chk_instr);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        send(f, op, rd, rs1, rs2, f3, f7, imm);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        if (chk_instr) chk({tag, " instr"}, out_instr, exp_instr);
        chk({tag, " err"}, 32'(out_err), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        in_fmt = '0;
        in_opcode = '0;
        in_rd = '0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm = '0;
        #3;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst enc_count", 32'(enc_count), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;

        xfer("I -1", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 2'd0, 1'b1);
        xfer("B -4", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE000EE3, 2'd0, 1'b1);
        xfer("B 3", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 2'd2, 1'b1);
        xfer("J 2048", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h001000EF, 2'd0, 1'b1);
        xfer("U", FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 2'd0, 1'b1);
        xfer("I 2048", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 2'd1, 1'b1);
        chk("enc_count mid", 32'(enc_count), 32'd5);
        chk("err_count mid", 32'(err_count), 32'd1);
        xfer("I 2047", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF00093, 2'd0, 1'b1);
        xfer("I -2048", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000093, 2'd0, 1'b1);
        xfer("B 4094", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E000FE3, 2'd0, 1'b1);
        xfer("B 4095", FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4095, 32'h7E000FE3, 2'd1, 1'b1);
        xfer("J min", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576, 32'h800000EF, 2'd0, 1'b1);
        xfer("J over", FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 32'h800000EF, 2'd1, 1'b1);
        xfer("U low", FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0, 2'd3, 1'b0);
        xfer("fmt 6", 3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd4, 32'h00000000, 2'd3, 1'b1);
        xfer("R sub", FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h7FFFFFFF, 32'h402081B3, 2'd0, 1'b1);
        xfer("S -4", FMT_S, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, -32'sd4, 32'hFE512E23, 2'd0, 1'b1);
        step();
        chk("drain out_valid", 32'(out_valid), 32'd0);
        chk("drain out_instr", out_instr, 32'd0);
        chk("enc_count 16", 32'(enc_count), 32'd16);
        chk("err_count 6", 32'(err_count), 32'd6);

        out_ready = 1'b0;
        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        chk("bp A valid", 32'(out_valid), 32'd1);
        chk("bp A head", out_instr, 32'h00100093);
        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        chk("bp head hold 1", out_instr, 32'h00100093);
        drive(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        chk("bp blocked in_ready", 32'(in_ready), 32'd0);
        chk("bp head hold 2", out_instr, 32'h00100093);
        chk("bp enc hold", 32'(enc_count), 32'd16);
        out_ready = 1'b1;
        step();
        chk("bp B head", out_instr, 32'h00200093);
        chk("bp in_ready back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp C head", out_instr, 32'h00300093);
        step();
        chk("bp empty", 32'(out_valid), 32'd0);
        chk("bp enc_count", 32'(enc_count), 32'd19);

        out_ready = 1'b0;
        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(FMT_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("fl full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl out_valid", 32'(out_valid), 32'd0);
        chk("fl in_ready", 32'(in_ready), 32'd1);
        chk("fl enc_count", 32'(enc_count), 32'd19);
        chk("fl err_count", 32'(err_count), 32'd6);
        flush = 1'b1;
        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        flush = 1'b0;
        chk("fl push override", 32'(out_valid), 32'd0);

        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        chk("rs buffered", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs async out_valid", 32'(out_valid), 32'd0);
        chk("rs async in_ready", 32'(in_ready), 32'd1);
        chk("rs async out_instr", out_instr, 32'd0);
        chk("rs enc_count", 32'(enc_count), 32'd0);
        chk("rs err_count", 32'(err_count), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        xfer("rs I -1", FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 2'd0, 1'b1);
        step();
        chk("rs enc_count 1", 32'(enc_count), 32'd1);
        chk("rs drained", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
